// File: rtl/fifo_rd_pkg.sv
// Shared state encoding and constants for the async-FIFO read-side drain.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } drain_state_t;

    localparam int READ_REG_COMB = 0;
    localparam int READ_REG_REGD = 1;
    localparam int SKID_DEPTH    = 2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry ordered buffer that absorbs FIFO read latency; head is the oldest word.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ,
    output logic             full
);

    logic [WIDTH-1:0] tail;

    assign full = (occ == 2'(SKID_DEPTH));

    // A push lands in head only when head would otherwise be empty after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Flow-controlled drain of the async FIFO read port onto a valid/ready stream,
// with delivered-word counting and burst completion pulses.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int MEMORY_WIDTH = 4,
    parameter int READ_REG     = 1,
    parameter int BURST_LEN    = 5,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    r_clk,
    input  logic                    rrst,
    input  logic                    enable,
    input  logic                    r_empty,
    input  logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    r_en,
    output logic                    m_valid,
    output logic [MEMORY_WIDTH-1:0] m_data,
    input  logic                    m_ready,
    output logic [COUNT_WIDTH-1:0]  rd_count,
    output logic                    burst_done
);

    localparam bit                 REGD_READ  = (READ_REG == READ_REG_REGD) || (READ_REG != READ_REG_COMB);
    localparam int                 BURST_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    drain_state_t            state;
    logic                    inflight;
    logic                    push;
    logic                    deliver;
    logic                    full;
    logic                    room;
    logic [1:0]              occ;
    logic [2:0]              load;
    logic [BURST_W-1:0]      burst_cnt;
    logic [MEMORY_WIDTH-1:0] head;

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign deliver = m_valid & m_ready;
    assign load    = {1'b0, occ} + {2'b0, inflight};

    // A full buffer never has a pop in flight, so it frees exactly one slot when it delivers.
    assign room = full ? deliver : ((load - {2'b0, deliver}) < 3'd2);
    assign r_en = enable & ~r_empty & (state == ACTIVE) & room;

    generate
        if (REGD_READ) begin : g_regd
            assign push = inflight;
            always_ff @(posedge r_clk) begin
                if (rrst) begin
                    inflight <= 1'b0;
                end else begin
                    inflight <= r_en;
                end
            end
        end else begin : g_comb
            assign push     = r_en;
            assign inflight = 1'b0;
        end
    endgenerate

    fifo_rd_skid_buf #(
        .WIDTH(MEMORY_WIDTH)
    ) u_skid (
        .clk      (r_clk),
        .rst      (rrst),
        .push     (push),
        .push_data(rdata),
        .pop      (deliver),
        .head     (head),
        .occ      (occ),
        .full     (full)
    );

    // STOPPING waits only for the in-flight read; buffered words drain from any state.
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!enable) state <= STOPPING;
                end
                STOPPING: begin
                    if (enable) begin
                        state <= ACTIVE;
                    end else if (!inflight) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            rd_count   <= '0;
            burst_cnt  <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (deliver) begin
                rd_count <= rd_count + COUNT_WIDTH'(1);
                if (burst_cnt == BURST_LAST) begin
                    burst_cnt  <= '0;
                    burst_done <= 1'b1;
                end else begin
                    burst_cnt <= burst_cnt + BURST_W'(1);
                end
            end
        end
    end

endmodule
